// File: rtl/commit_ctrl_if.sv
// commit_ctrl_if: ROB head, store handshake and write-back signals between the ROB side and commit_ctrl.
interface commit_ctrl_if #(parameter int rob_index_bits = 4);
    logic                      head_valid;
    logic [4:0]                head_rd;
    logic [31:0]               head_data;
    logic                      head_is_store;
    logic                      head_mispredict;
    logic [31:0]               head_target;
    logic                      st_req;
    logic                      st_ack;
    logic                      rf_load;
    logic [4:0]                rf_idx;
    logic [31:0]               rf_data;
    logic [rob_index_bits-1:0] rob_head;
    logic                      rob_pop;
    logic                      flush;
    logic [31:0]               redirect_pc;
    logic [31:0]               commit_cnt;

    modport master (
        input  head_valid, head_rd, head_data, head_is_store, head_mispredict, head_target, st_ack,
        output st_req, rf_load, rf_idx, rf_data, rob_head, rob_pop, flush, redirect_pc, commit_cnt
    );
    modport slave (
        output head_valid, head_rd, head_data, head_is_store, head_mispredict, head_target, st_ack,
        input  st_req, rf_load, rf_idx, rf_data, rob_head, rob_pop, flush, redirect_pc, commit_cnt
    );
endinterface

// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order ROB commit sequencer with store handshake and mispredict flush.
// COMMIT_PERF_CNT_EN enables the retired-instruction counter; otherwise commit_cnt is tied to 0.
module commit_ctrl #(
    parameter int rob_index_bits = 4
) (
    input logic          clk,
    input logic          rst,
    commit_ctrl_if.master cc_if
);
    typedef enum logic [1:0] {RUN, ST_WAIT, FLUSH} state_e;

    state_e                    state_q, state_d;
    logic [rob_index_bits-1:0] head_q, head_d;
    logic [31:0]               pc_q, pc_d;
    logic                      pop, load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            head_q  <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pop     = 1'b0;
        load    = 1'b0;
        case (state_q)
            RUN: if (cc_if.head_valid) begin
                if (cc_if.head_is_store) begin
                    state_d = ST_WAIT;
                end else begin
                    pop  = 1'b1;
                    load = cc_if.head_rd != 5'd0;
                    if (cc_if.head_mispredict) begin
                        pc_d    = cc_if.head_target;
                        state_d = FLUSH;
                    end
                end
            end
            ST_WAIT: if (cc_if.st_ack) begin
                pop     = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        head_d = head_q + rob_index_bits'(pop);
    end

    assign cc_if.rob_pop     = pop;
    assign cc_if.rf_load     = load;
    assign cc_if.rf_idx      = cc_if.head_rd;
    assign cc_if.rf_data     = cc_if.head_data;
    assign cc_if.rob_head    = head_q;
    assign cc_if.st_req      = state_q == ST_WAIT;
    assign cc_if.flush       = state_q == FLUSH;
    assign cc_if.redirect_pc = pc_q;

`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt_q <= '0;
        else if (pop) cnt_q <= cnt_q + 32'd1;
    end

    assign cc_if.commit_cnt = cnt_q;
`else
    assign cc_if.commit_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: scoreboard bench for commit_ctrl; expected outputs are queued as stimulus is driven.
module tb_commit_ctrl;
    typedef struct packed {
        logic        pop;
        logic        load;
        logic        st_req;
        logic        flush;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [3:0]  head;
        logic [31:0] pc;
        logic [31:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    obs_t sbq[$];
    obs_t got, exp_o;
    logic [3:0]  exp_head = '0;
    logic [31:0] exp_cnt = '0;
    logic [31:0] exp_pc = '0;

    commit_ctrl_if #(.rob_index_bits(4)) cc_if ();
    commit_ctrl #(.rob_index_bits(4)) dut (.clk(clk), .rst(rst), .cc_if(cc_if));

    always #5 clk = ~clk;

    task automatic drv(input logic v, input logic [4:0] rd, input logic [31:0] data,
                       input logic st, input logic mp, input logic [31:0] tgt, input logic ack);
        cc_if.head_valid      = v;
        cc_if.head_rd         = rd;
        cc_if.head_data       = data;
        cc_if.head_is_store   = st;
        cc_if.head_mispredict = mp;
        cc_if.head_target     = tgt;
        cc_if.st_ack          = ack;
    endtask

    task automatic push(input logic p, input logic l, input logic s, input logic f);
        obs_t e;
        logic [31:0] c;
`ifdef COMMIT_PERF_CNT_EN
        c = exp_cnt;
`else
        c = 32'h0;
`endif
        e = {p, l, s, f, cc_if.head_rd, cc_if.head_data, exp_head, exp_pc, c};
        sbq.push_back(e);
        exp_head = exp_head + 4'(p);
        exp_cnt  = exp_cnt + 32'(p);
    endtask

    task automatic model_reset();
        exp_head = '0;
        exp_cnt  = '0;
        exp_pc   = '0;
    endtask

    task automatic sample();
        got = {cc_if.rob_pop, cc_if.rf_load, cc_if.st_req, cc_if.flush, cc_if.rf_idx,
               cc_if.rf_data, cc_if.rob_head, cc_if.redirect_pc, cc_if.commit_cnt};
        exp_o = sbq.pop_front();
    endtask

    task automatic test_reset();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        push(0, 0, 0, 0);
        #1 sample();
        checks++;
        if (got !== exp_o) begin errors++; $display("FAIL reset_hold got %h exp %h", got, exp_o); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin drv(1, 3, 32'h11, 0, 0, 0, 0); push(1, 1, 0, 0); end
            if (i == 1) begin drv(1, 2, 32'h22, 0, 1, 32'h1234, 0); push(1, 1, 0, 0); exp_pc = 32'h1234; end
            if (i == 2) begin drv(0, 0, 0, 0, 0, 0, 0); push(0, 0, 0, 1); end
            #1 sample();
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL reset_pre cyc %0d got %h exp %h", i, got, exp_o); end
        end
        #1 rst = 1'b1;
        model_reset();
        push(0, 0, 0, 0);
        #1 sample();
        checks++;
        if (got !== exp_o) begin errors++; $display("FAIL reset_async got %h exp %h", got, exp_o); end
        #1 rst = 1'b0;
    endtask

    task automatic test_commit_wrap();
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (i < 20) begin drv(1, 5, 32'hA5A5_0000 + 32'(i), 0, 0, 0, 0); push(1, 1, 0, 0); end
            else begin drv(0, 0, 0, 0, 0, 0, 0); push(0, 0, 0, 0); end
            #1 sample();
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL commit_wrap cyc %0d got %h exp %h", i, got, exp_o); end
        end
    endtask

    task automatic test_x0();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) begin drv(1, 0, 32'hCAFE, 0, 0, 0, 0); push(1, 0, 0, 0); end
            else begin drv(0, 0, 0, 0, 0, 0, 0); push(0, 0, 0, 0); end
            #1 sample();
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL x0 cyc %0d got %h exp %h", i, got, exp_o); end
        end
    endtask

    task automatic test_store();
        // detect, three waits, ack, idle; mispredict flag on the store must be ignored
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) begin drv(1, 7, 32'h77, 1, 1, 32'h999, 0); push(0, 0, 0, 0); end
            else if (i < 4) begin drv(1, 7, 32'h77, 1, 1, 32'h999, 0); push(0, 0, 1, 0); end
            else if (i == 4) begin drv(1, 7, 32'h77, 1, 1, 32'h999, 1); push(1, 0, 1, 0); end
            else begin drv(0, 0, 0, 0, 0, 0, 0); push(0, 0, 0, 0); end
            #1 sample();
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL store cyc %0d got %h exp %h", i, got, exp_o); end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drv(1, 8, 32'h88, 1, 0, 0, 0);
            push(0, 0, i == 1, 0);
            #1 sample();
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL store2 cyc %0d got %h exp %h", i, got, exp_o); end
        end
        #1 rst = 1'b1;
        model_reset();
        push(0, 0, 0, 0);
        #1 sample();
        checks++;
        if (got !== exp_o) begin errors++; $display("FAIL store_rst got %h exp %h", got, exp_o); end
        drv(0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
    endtask

    task automatic test_mispredict();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin drv(1, 1, 32'hDEAD, 0, 1, 32'h0000_0400, 0); push(1, 1, 0, 0); exp_pc = 32'h400; end
            else if (i == 1) begin drv(1, 9, 32'h99, 0, 0, 0, 0); push(0, 0, 0, 1); end
            else if (i == 2) begin drv(1, 9, 32'h99, 0, 0, 0, 0); push(1, 1, 0, 0); end
            else begin drv(0, 0, 0, 0, 0, 0, 0); push(0, 0, 0, 0); end
            #1 sample();
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL mispredict cyc %0d got %h exp %h", i, got, exp_o); end
        end
    endtask

    task automatic test_stale_ack();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin drv(1, 4, 32'h44, 0, 0, 0, 1); push(1, 1, 0, 0); end
            else if (i == 1) begin drv(0, 0, 0, 0, 0, 0, 1); push(0, 0, 0, 0); end
            else begin drv(1, 6, 32'h66, 0, 0, 0, 0); push(1, 1, 0, 0); end
            #1 sample();
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL stale_ack cyc %0d got %h exp %h", i, got, exp_o); end
        end
    endtask

    initial begin
        test_reset();
        test_commit_wrap();
        test_x0();
        test_store();
        test_mispredict();
        test_stale_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
